// File: rtl/clken_gen_pkg.sv
// clken_gen_pkg: shared FSM state type, settle-counter width and the
// channel-index width helper used by the clock-enable generator.
package clken_gen_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int CNT_W = 16;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clken_gen_acc.sv
// clken_gen_acc: one clock-enable channel. A phase accumulator adds the
// channel increment every refclk cycle; the carry out is registered as the
// enable pulse, suppressed while the channel is held, loaded or realigned.
// Optional feature macro: CLKEN_GEN_PHASE_EN adds a per-channel start phase
// that is applied on load and on sync.
module clken_gen_acc #(
  parameter int ACC_W = 32
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic [ACC_W-1:0] rst_inc,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
`ifdef CLKEN_GEN_PHASE_EN
  input  logic [ACC_W-1:0] load_phase,
`endif
  input  logic             sync,
  input  logic             hold,
  output logic             clken
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;
`ifdef CLKEN_GEN_PHASE_EN
  logic [ACC_W-1:0] phase;
`endif

  assign sum = {1'b0, acc} + {1'b0, inc};

  // Accumulate, register the carry as the pulse, and apply load/realign.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      acc   <= '0;
      inc   <= rst_inc;
      clken <= 1'b0;
`ifdef CLKEN_GEN_PHASE_EN
      phase <= '0;
`endif
    end else begin
      // A sum that is about to be discarded by load or sync never pulses.
      clken <= sum[ACC_W] & ~sync & ~hold & ~load;
      if (load) begin
        inc   <= load_inc;
`ifdef CLKEN_GEN_PHASE_EN
        acc   <= load_phase;
        phase <= load_phase;
`else
        acc   <= '0;
`endif
      end else if (sync) begin
`ifdef CLKEN_GEN_PHASE_EN
        acc <= phase;
`else
        acc <= '0;
`endif
      end else begin
        acc <= sum[ACC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/clken_gen.sv
// clken_gen: NUM_CH phase-accumulator clock-enable generators with a
// settle/lock sequencer and a single-channel reconfiguration handshake.
// Optional feature macro: CLKEN_GEN_PHASE_EN (adds cfg_phase input).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   SETTLE | counting down cnt; locked=0, cfg_ready=0, target ch muted
//   LOCKED | all channels at configured rate; reconfiguration accepted
module clken_gen
  import clken_gen_pkg::*;
#(
  parameter int                      NUM_CH      = 5,
  parameter int                      ACC_W       = 32,
  parameter int                      LOCK_CYCLES = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] DEFAULT_INC = '0
) (
  input  logic                        refclk,
  input  logic                        rst_n,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]            cfg_inc,
`ifdef CLKEN_GEN_PHASE_EN
  input  logic [ACC_W-1:0]            cfg_phase,
`endif
  input  logic                        sync,
  output logic [NUM_CH-1:0]           clken,
  output logic                        locked
);

  localparam int                IDX_W    = ch_idx_w(NUM_CH);
  localparam logic [CNT_W-1:0]  LOCK_CNT = CNT_W'(LOCK_CYCLES);
  localparam logic [IDX_W:0]    NUM_CH_W = (IDX_W + 1)'(NUM_CH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] sel;
  logic             first_lock;
  logic             xfer_hit;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] hold;

  // Out-of-range channel writes complete the handshake but touch nothing.
  assign xfer_hit = cfg_valid && cfg_ready && ({1'b0, cfg_ch} < NUM_CH_W);

  // Settle/lock sequencer with registered locked and cfg_ready.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state      <= SETTLE;
      cnt        <= LOCK_CNT;
      sel        <= '0;
      first_lock <= 1'b0;
      locked     <= 1'b0;
      cfg_ready  <= 1'b0;
    end else begin
      case (state)
        SETTLE: begin
          if (cnt == '0) begin
            state      <= LOCKED;
            first_lock <= 1'b1;
            locked     <= 1'b1;
            cfg_ready  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        LOCKED: begin
          if (xfer_hit) begin
            state     <= SETTLE;
            cnt       <= LOCK_CNT;
            sel       <= cfg_ch;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
          end
        end
        default: begin
          state <= SETTLE;
          cnt   <= LOCK_CNT;
        end
      endcase
    end
  end

  // Until the first lock every channel is muted; afterwards only the
  // channel being reconfigured is muted while settling.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign load[g] = xfer_hit && (cfg_ch == IDX_W'(g));
    assign hold[g] = (state == SETTLE) && (!first_lock || (sel == IDX_W'(g)));

    clken_gen_acc #(
      .ACC_W (ACC_W)
    ) u_acc (
      .refclk     (refclk),
      .rst_n      (rst_n),
      .rst_inc    (DEFAULT_INC[g*ACC_W +: ACC_W]),
      .load       (load[g]),
      .load_inc   (cfg_inc),
`ifdef CLKEN_GEN_PHASE_EN
      .load_phase (cfg_phase),
`endif
      .sync       (sync),
      .hold       (hold[g]),
      .clken      (clken[g])
    );
  end

endmodule
